tone_period_meter: RTL and testbench
====================================

Name: tone_period_meter

Overview:
- Input-side counterpart of the board buzzer path. Samples a 1-bit square wave, for example the buzzer output looped back or an external tone, on the 50 MHz system clock.
- Measures the full period and the high time in clock cycles, and flags loss of tone.
- Feeds the seven-segment and LED display logic with a fresh measurement after every rising edge of the tone.

Parameters:
- CNT_W, 24, width of the period and high-time counters and outputs.
- SYNC_STAGES, 2, flip-flop stages on tone_in before edge detection; minimum 2.
- TIMEOUT, 5000000, cycles without a rising edge before no_tone asserts (100 ms at 50 MHz). Must satisfy 2 <= TIMEOUT <= 2^CNT_W - 1.

Ports:
- clk  input  1  system clock, 50 MHz.
- rst  input  1  asynchronous, active-high reset.
- tone_in  input  1  asynchronous square-wave input.
- period  output  CNT_W  last measured rising-to-rising period, in clk cycles.
- high_time  output  CNT_W  high-phase length of that same period, in clk cycles.
- period_valid  output  1  one-cycle strobe; period and high_time have just updated.
- no_tone  output  1  level; no rising edge seen within TIMEOUT cycles.

Behaviour:
- Reset values: period=0, high_time=0, period_valid=0, no_tone=1, all sync flops=0, cnt=0, hi_lat=0, state=IDLE.
- Synchronizer:
  - tone_in passes through SYNC_STAGES flops, then one more flop, s_d.
  - rise = s & ~s_d; fall = ~s & s_d.
  - Edge-detect latency is SYNC_STAGES+1 cycles. It is constant, so it does not bias the measurements.
- State IDLE (no reference edge held):
  - cnt holds at 0.
  - On rise: cnt <= 0, go to MEAS. no_tone is unchanged.
- State MEAS: cnt increments by 1 each cycle.
  - On fall: hi_lat <= cnt+1.
  - On rise, with cnt+1 < TIMEOUT:
    - period <= cnt+1 and high_time <= hi_lat.
    - period_valid pulses for one cycle, registered in the same clock as the rise update.
    - no_tone <= 0; cnt <= 0; stay in MEAS.
  - Timeout, when cnt == TIMEOUT-1 with no rise in that cycle:
    - no_tone <= 1, go to IDLE, cnt <= 0.
    - No period_valid. period and high_time keep their last values.
  - A rise in the same cycle that cnt == TIMEOUT-1 counts as a timeout; the rise is ignored. The next rise re-arms from IDLE.
- Example: a steady wave with period P and high time H (P < TIMEOUT) gives period=P and high_time=H, starting from the second rising edge.
- The first rise after reset or timeout only arms the meter and produces no strobe.
- Rise and fall cannot occur in the same cycle, because both derive from one synchronized bit.
- Counter arithmetic: unsigned, CNT_W bits. Because TIMEOUT bounds cnt, cnt never wraps.
- rst asserted mid-measurement: all state returns to reset values immediately, with no strobe. After release, the meter needs two rising edges before the next strobe.
- Inputs faster than clk/4 are outside the specified range; behaviour there is don't-care, but no X may propagate.

Optional Feature:
- Macro: TONE_AVG4_EN.
- Defined:
  - Each raw period and raw high time is accumulated in CNT_W+2-bit accumulators.
  - After every 4th raw measurement: period <= sum>>2, high_time <= sum>>2 (truncated), period_valid pulses, accumulators clear.
  - Timeout or reset clears the accumulators and the 0-3 measurement count.
- Not defined: every raw measurement is output directly, as described above.

Test Plan:
- Reset, then hold tone_in=0 for 10 cycles -> no_tone=1, period=0, high_time=0, no period_valid.
- Drive a square wave with a 65536-cycle period and 50% duty (buzzer on counter bit 15), 4 rising edges -> 3 strobes, each with period=65536 and high_time=32768; no_tone falls on the first strobe.
- TIMEOUT=1000: one rise, then tone_in held low for 1200 cycles -> no_tone=1 exactly 1000 cycles after the arm, no strobe. The next two rises with spacing 400 -> period=400.
- Duty sweep at period 100, high times 1, 25, 99 -> high_time = 1, 25, 99 and period=100 for each.
- Assert rst mid-period, 40 cycles after a rise -> all outputs return to reset values; the first strobe after release comes only on the second rise.
- With TONE_AVG4_EN defined, periods 100, 102, 104, 107 -> a single strobe after the 4th measurement, period=103 (413>>2). No strobe after measurements 1-3.

Source files
------------

// File: rtl/tone_period_meter.sv
// tone_period_meter: measures period and high time of a square wave on clk.
// Macro TONE_AVG4_EN: output the mean of every 4 raw measurements instead.
//
// Ports:
//   clk          system clock
//   rst          asynchronous, active-high reset
//   tone_in      asynchronous square-wave input
//   period       last rising-to-rising period, in clk cycles
//   high_time    high-phase length of that same period, in clk cycles
//   period_valid one-cycle strobe when period/high_time update
//   no_tone      no rising edge within TIMEOUT cycles
module tone_period_meter #(
    parameter int CNT_W       = 24,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 5000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tone_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             period_valid,
    output logic             no_tone
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic {
        IDLE,
        MEAS
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync;
    logic                   s_d;
    logic                   s;
    logic                   rise;
    logic                   fall;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_inc;
    logic [CNT_W-1:0]       hi_lat;

    assign s       = sync[SYNC_STAGES-1];
    assign rise    = s & ~s_d;
    assign fall    = ~s & s_d;
    assign cnt_inc = cnt + 1'b1;

`ifdef TONE_AVG4_EN
    logic [CNT_W+1:0] acc_p;
    logic [CNT_W+1:0] acc_h;
    logic [CNT_W+1:0] sum_p;
    logic [CNT_W+1:0] sum_h;
    logic [1:0]       n_avg;

    // Sums include the measurement being taken this cycle.
    assign sum_p = acc_p + {2'b00, cnt_inc};
    assign sum_h = acc_h + {2'b00, hi_lat};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '0;
            s_d  <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], tone_in};
            s_d  <= s;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            hi_lat       <= '0;
            period       <= '0;
            high_time    <= '0;
            period_valid <= 1'b0;
            no_tone      <= 1'b1;
`ifdef TONE_AVG4_EN
            acc_p        <= '0;
            acc_h        <= '0;
            n_avg        <= '0;
`endif
        end else begin
            period_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (rise) begin
                        state <= MEAS;
                    end
                end
                MEAS: begin
                    if (fall) begin
                        hi_lat <= cnt_inc;
                    end
                    // Timeout wins over a rise landing in the same cycle.
                    if (cnt == CNT_LAST) begin
                        state   <= IDLE;
                        cnt     <= '0;
                        no_tone <= 1'b1;
`ifdef TONE_AVG4_EN
                        acc_p   <= '0;
                        acc_h   <= '0;
                        n_avg   <= '0;
`endif
                    end else if (rise) begin
                        cnt     <= '0;
                        no_tone <= 1'b0;
`ifdef TONE_AVG4_EN
                        if (n_avg == 2'd3) begin
                            period       <= sum_p[CNT_W+1:2];
                            high_time    <= sum_h[CNT_W+1:2];
                            period_valid <= 1'b1;
                            acc_p        <= '0;
                            acc_h        <= '0;
                            n_avg        <= '0;
                        end else begin
                            acc_p <= sum_p;
                            acc_h <= sum_h;
                            n_avg <= n_avg + 2'd1;
                        end
`else
                        period       <= cnt_inc;
                        high_time    <= hi_lat;
                        period_valid <= 1'b1;
`endif
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tone_period_meter.sv
// Bench for tone_period_meter: random and directed tones against a
// timestamp-based reference model, checked every cycle.
module tb_tone_period_meter;

    localparam int CNT_W = 24;
    localparam int SYNC  = 2;
    localparam int TO    = 1000;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             tone_in = 1'b0;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             period_valid;
    logic             no_tone;

    always #10 clk = ~clk;

    tone_period_meter #(
        .CNT_W      (CNT_W),
        .SYNC_STAGES(SYNC),
        .TIMEOUT    (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tone_in     (tone_in),
        .period      (period),
        .high_time   (high_time),
        .period_valid(period_valid),
        .no_tone     (no_tone)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)",
                     tag, obs, exp, $time);
        end
    endtask

    // Reference model: remembers edge timestamps; the synchronizer
    // is just a fixed delay on the sampled input.
    int   cyc = 0;
    logic hist [0:SYNC+1];
    bit   armed = 0;
    int   t_ref = 0;
    int   t_fall = 0;
    int   m_p = 0;
    int   m_h = 0;
    bit   m_v = 0;
    bit   m_nt = 1;
    int   acc_p = 0;
    int   acc_h = 0;
    int   n_avg = 0;

    task automatic measured(input int p, input int h);
`ifdef TONE_AVG4_EN
        acc_p += p;
        acc_h += h;
        n_avg++;
        if (n_avg == 4) begin
            m_p   = acc_p / 4;
            m_h   = acc_h / 4;
            m_v   = 1;
            acc_p = 0;
            acc_h = 0;
            n_avg = 0;
        end
`else
        m_p = p;
        m_h = h;
        m_v = 1;
`endif
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc   = 0;
            for (int k = 0; k <= SYNC + 1; k++) hist[k] = 1'b0;
            armed = 0;
            m_p   = 0;
            m_h   = 0;
            m_v   = 0;
            m_nt  = 1;
            acc_p = 0;
            acc_h = 0;
            n_avg = 0;
        end else begin
            bit r, f;
            int d;
            cyc++;
            for (int k = SYNC + 1; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = tone_in;
            r   = hist[SYNC] && !hist[SYNC+1];
            f   = !hist[SYNC] && hist[SYNC+1];
            m_v = 0;
            if (armed) begin
                d = cyc - t_ref;
                if (d >= TO) begin
                    armed = 0;
                    m_nt  = 1;
                    acc_p = 0;
                    acc_h = 0;
                    n_avg = 0;
                end else if (r) begin
                    measured(d, t_fall - t_ref);
                    m_nt  = 0;
                    t_ref = cyc;
                end else if (f) begin
                    t_fall = cyc;
                end
            end else if (r) begin
                armed = 1;
                t_ref = cyc;
            end
        end
    end

    int n_strobe = 0;
    int last_p   = 0;
    int last_h   = 0;

    always @(negedge clk) begin
        chk("period_valid", 32'(period_valid), 32'(m_v));
        chk("no_tone", 32'(no_tone), 32'(m_nt));
        chk("period", 32'(period), m_p);
        chk("high_time", 32'(high_time), m_h);
        if (period_valid === 1'b1) begin
            n_strobe++;
            last_p = int'(period);
            last_h = int'(high_time);
        end
    end

    task automatic tone(input int h, input int l);
        @(negedge clk) tone_in = 1'b1;
        repeat (h - 1) @(negedge clk);
        @(negedge clk) tone_in = 1'b0;
        repeat (l - 1) @(negedge clk);
    endtask

    task automatic idle(input int n);
        tone_in = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    int s0;
    int p_r;
    int h_r;
    int duty [3] = '{1, 25, 99};

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle(10);
        chk("rst_period", 32'(period), 0);
        chk("rst_high", 32'(high_time), 0);
        chk("rst_no_tone", 32'(no_tone), 1);
        chk("rst_strobes", n_strobe, 0);

        s0 = n_strobe;
        repeat (4) tone(256, 256);
`ifndef TONE_AVG4_EN
        chk("steady_strobes", n_strobe - s0, 3);
        chk("steady_period", last_p, 512);
        chk("steady_high", last_h, 256);
`endif
        chk("steady_no_tone", 32'(no_tone), 0);

        foreach (duty[i]) begin
            tone(duty[i], 100 - duty[i]);
            tone(duty[i], 100 - duty[i]);
`ifndef TONE_AVG4_EN
            chk("duty_period", last_p, 100);
            chk("duty_high", last_h, duty[i]);
`endif
        end

        s0 = n_strobe;
        tone(2, 1200);
        chk("timeout_no_tone", 32'(no_tone), 1);
        tone(2, 398);
        tone(2, 398);
        tone(2, 10);
`ifndef TONE_AVG4_EN
        chk("rearm_period", last_p, 400);
        chk("rearm_strobes", n_strobe - s0, 3);
`endif

        tone(2, 997);
        tone(2, 998);
        tone(5, 5);
        tone(5, 5);
        tone(5, 5);

        tone(20, 20);
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("mid_rst_period", 32'(period), 0);
        chk("mid_rst_high", 32'(high_time), 0);
        chk("mid_rst_no_tone", 32'(no_tone), 1);
        rst = 1'b0;
        s0 = n_strobe;
        tone(30, 70);
        chk("arm_no_strobe", n_strobe - s0, 0);
        tone(30, 70);
`ifndef TONE_AVG4_EN
        chk("second_rise_strobe", n_strobe - s0, 1);
`endif

        repeat (30) begin
            p_r = int'($urandom_range(1100, 8));
            h_r = int'($urandom_range(p_r - 2, 2));
            repeat (int'($urandom_range(5, 1))) tone(h_r, p_r - h_r);
        end

`ifdef TONE_AVG4_EN
        idle(1100);
        s0 = n_strobe;
        tone(2, 98);
        tone(2, 100);
        tone(2, 102);
        tone(2, 105);
        tone(2, 20);
        chk("avg_strobes", n_strobe - s0, 1);
        chk("avg_period", last_p, 103);
        chk("avg_high", last_h, 2);
`endif

        idle(20);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
